// File: rtl/vga_timing_gen.sv
// Raster timing for the 640x480 path: pixel tick, h/v counters, syncs, blank, vblank_start.
// Latency: every output is a register loaded on the pixel-tick edge; no input-to-output path.
// Backpressure: none; free-running, only reset stops it.
module vga_timing_gen #(
    parameter int   CLK_DIV     = 2,
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_tick,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic       vblank_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div;
    logic             div_last;
    logic [9:0]       h_next;
    logic [9:0]       v_next;

    assign div_last = (div == DIV_LAST);

    always_comb begin
        h_next = hcount + 10'd1;
        v_next = vcount;
        if (hcount == H_LAST) begin
            h_next = '0;
            v_next = (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end
    end

    // Decodes use the next counter values so they line up with the counters they accompany.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div          <= '0;
            pix_tick     <= 1'b0;
            hcount       <= '0;
            vcount       <= '0;
            hsync        <= ~SYNC_ACTIVE;
            vsync        <= ~SYNC_ACTIVE;
            blank        <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            pix_tick     <= div_last;
            vblank_start <= 1'b0;
            div          <= div_last ? '0 : div + 1'b1;
            if (div_last) begin
                hcount       <= h_next;
                vcount       <= v_next;
                blank        <= (h_next >= H_VIS) || (v_next >= V_VIS);
                hsync        <= ((h_next >= HS_START) && (h_next < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vsync        <= ((v_next >= VS_START) && (v_next < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vblank_start <= (h_next == '0) && (v_next == V_VIS);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, small-geometry and inverted-sync/CLK_DIV=1 instances
// checked every clock against a closed-form raster model, plus directed tables and sequences.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       d_tick, d_hs, d_vs, d_bl, d_vb;
    logic [9:0] d_h, d_v;
    logic       s_tick, s_hs, s_vs, s_bl, s_vb;
    logic [9:0] s_h, s_v;
    logic       o_tick, o_hs, o_vs, o_bl, o_vb;
    logic [9:0] o_h, o_v;
    logic [24:0] d_o, s_o, o_o;

    assign d_o = {d_tick, d_h, d_v, d_hs, d_vs, d_bl, d_vb};
    assign s_o = {s_tick, s_h, s_v, s_hs, s_vs, s_bl, s_vb};
    assign o_o = {o_tick, o_h, o_v, o_hs, o_vs, o_bl, o_vb};

    vga_timing_gen u_def (
        .clk(clk), .reset(reset), .pix_tick(d_tick), .hcount(d_h), .vcount(d_v),
        .hsync(d_hs), .vsync(d_vs), .blank(d_bl), .vblank_start(d_vb)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_ACTIVE(1'b0)
    ) u_sm (
        .clk(clk), .reset(reset), .pix_tick(s_tick), .hcount(s_h), .vcount(s_v),
        .hsync(s_hs), .vsync(s_vs), .blank(s_bl), .vblank_start(s_vb)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_ACTIVE(1'b1)
    ) u_ov (
        .clk(clk), .reset(reset), .pix_tick(o_tick), .hcount(o_h), .vcount(o_v),
        .hsync(o_hs), .vsync(o_vs), .blank(o_bl), .vblank_start(o_vb)
    );

    // Clock edges seen since reset was last released.
    int kcnt;
    always @(posedge clk or posedge reset) begin
        if (reset) kcnt <= 0;
        else       kcnt <= kcnt + 1;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic cmp(input string nm, input logic [24:0] got, input logic [24:0] exp_v);
        n_assert++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s k=%0d got=%h expected=%h", nm, kcnt, got, exp_v);
        end
    endtask

    function automatic logic [24:0] mk(input logic t, input int h, input int v,
                                       input logic hs, input logic vs, input logic bl, input logic vb);
        return {t, 10'(h), 10'(v), hs, vs, bl, vb};
    endfunction

    // Raster position after k edges: pixel index k/d, laid out row-major over the total frame.
    function automatic logic [24:0] ref_out(input int k, input int d,
                                            input int hv, input int hf, input int hs, input int hb,
                                            input int vv, input int vf, input int vs, input int vb,
                                            input logic sa);
        int   n, h, v, ht, vt;
        logic t, bl, hsy, vsy, vbs;
        ht  = hv + hf + hs + hb;
        vt  = vv + vf + vs + vb;
        t   = (k > 0) && (k % d == 0);
        n   = k / d;
        h   = n % ht;
        v   = (n / ht) % vt;
        bl  = (h >= hv) || (v >= vv);
        hsy = (h >= hv + hf && h < hv + hf + hs) ? sa : ~sa;
        vsy = (v >= vv + vf && v < vv + vf + vs) ? sa : ~sa;
        vbs = t && (h == 0) && (v == vv);
        return mk(t, h, v, hsy, vsy, bl, vbs);
    endfunction

    always @(negedge clk) begin
        cmp("def_model", d_o, ref_out(kcnt, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        cmp("sm_model",  s_o, ref_out(kcnt, 3, 8, 2, 3, 2, 6, 1, 2, 1, 1'b0));
        cmp("ov_model",  o_o, ref_out(kcnt, 1, 8, 2, 3, 2, 6, 1, 2, 1, 1'b1));
    end

    typedef struct {
        int          k;
        logic [24:0] exp_v;
    } vec_t;
    vec_t tbl[13];

    task automatic run_table();
        for (int i = 0; i < 13; i++) begin
            for (int g = 0; g < 5000 && kcnt < tbl[i].k; g++) @(negedge clk);
            #1;
            cmp($sformatf("tbl%0d_k%0d", i, tbl[i].k), d_o, tbl[i].exp_v);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_vbs(input int sel, input int exp_k, input string nm);
        logic hit;
        int   at;
        hit = 1'b0;
        at  = -1;
        for (int g = 0; g < 2000 && !hit; g++) begin
            @(negedge clk);
            #1;
            hit = (sel == 0) ? o_vb : s_vb;
            if (hit) at = kcnt;
        end
        cmp(nm, 25'(at), 25'(exp_k));
        @(negedge clk);
        #1;
        cmp({nm, "_width"}, 25'((sel == 0) ? o_vb : s_vb), 25'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at kcnt=%0d", kcnt);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0,    mk(0, 0,   0, 1, 1, 0, 0)};
        tbl[1]  = '{1,    mk(0, 0,   0, 1, 1, 0, 0)};
        tbl[2]  = '{2,    mk(1, 1,   0, 1, 1, 0, 0)};
        tbl[3]  = '{3,    mk(0, 1,   0, 1, 1, 0, 0)};
        tbl[4]  = '{1278, mk(1, 639, 0, 1, 1, 0, 0)};
        tbl[5]  = '{1280, mk(1, 640, 0, 1, 1, 1, 0)};
        tbl[6]  = '{1311, mk(0, 655, 0, 1, 1, 1, 0)};
        tbl[7]  = '{1312, mk(1, 656, 0, 0, 1, 1, 0)};
        tbl[8]  = '{1502, mk(1, 751, 0, 0, 1, 1, 0)};
        tbl[9]  = '{1504, mk(1, 752, 0, 1, 1, 1, 0)};
        tbl[10] = '{1598, mk(1, 799, 0, 1, 1, 1, 0)};
        tbl[11] = '{1600, mk(1, 0,   1, 1, 1, 0, 0)};
        tbl[12] = '{1601, mk(0, 0,   1, 1, 1, 0, 0)};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        cmp("rst_def", d_o, mk(0, 0, 0, 1, 1, 0, 0));
        cmp("rst_ov",  o_o, mk(0, 0, 0, 0, 0, 0, 0));

        release_reset();
        run_table();

        // Mid-line reset at pixel 300, asserted between edges.
        @(posedge clk); #2 reset = 1'b1;
        release_reset();
        for (int g = 0; g < 2000 && kcnt < 600; g++) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        cmp("async_rst_def", d_o, mk(0, 0, 0, 1, 1, 0, 0));
        cmp("async_rst_sm",  s_o, mk(0, 0, 0, 1, 1, 0, 0));
        cmp("async_rst_ov",  o_o, mk(0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        release_reset();
        run_table();

        // Frame boundaries on the small-geometry instances.
        @(posedge clk); #2 reset = 1'b1;
        release_reset();
        wait_vbs(0, 90,  "ov_vbs_first");
        wait_vbs(0, 240, "ov_vbs_second");
        wait_vbs(1, 270, "sm_vbs_first");
        wait_vbs(1, 720, "sm_vbs_second");

        for (int it = 0; it < 15; it++) begin
            repeat ($urandom_range(1, 1500)) @(negedge clk);
            @(posedge clk);
            #($urandom_range(1, 4)) reset = 1'b1;
            #1;
            cmp("rand_async_rst", d_o, mk(0, 0, 0, 1, 1, 0, 0));
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #($urandom_range(1, 4)) reset = 1'b0;
        end
        repeat (500) @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
